// File: rtl/monolith_sponge_ctrl.sv
// Sponge-mode sequencer for a Monolith permutation core over GF(2^31-1).
// Absorbs RATE message elements per permutation into a 16-lane state.
// Applies 10* padding, drives the held-go permutation handshake, then
// squeezes OUT_LEN digest elements out on a valid/ready stream.
module monolith_sponge_ctrl #(
  parameter int RATE    = 8,
  parameter int OUT_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [30:0]       in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [30:0]       out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              perm_go,
  output logic [15:0][30:0] perm_state_in,
  input  logic [15:0][30:0] perm_state_out,
  input  logic              perm_valid,
  output logic              busy
);

  localparam logic [30:0] P_MOD     = 31'h7FFF_FFFF;
  localparam logic [3:0]  RATE_LAST = 4'(RATE - 1);
  localparam logic [3:0]  OUT_LAST  = 4'(OUT_LEN - 1);

  typedef enum logic [1:0] {
    S_ABSORB  = 2'd0,
    S_PAD     = 2'd1,
    S_PERM    = 2'd2,
    S_SQUEEZE = 2'd3
  } fsm_t;

  fsm_t              fsm_r;
  logic [15:0][30:0] state_r;
  logic [3:0]        cnt_r;
  logic [3:0]        idx_r;
  logic              final_r;
  logic              need_pad_r;
  logic              in_ready_r;
  logic              perm_go_r;
  logic              out_valid_r;
  logic              out_last_r;

  logic [30:0]       in_red_s;
  logic [30:0]       lane_sum_s;
  logic              in_fire_s;
  logic              out_fire_s;

  // Modular addition of two reduced field elements.
  function automatic logic [30:0] fadd(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) begin
      s = s - {1'b0, P_MOD};
    end else begin
      s = s;
    end
    return s[30:0];
  endfunction

  // Reduce the input element and form the sum for the lane selected by cnt.
  always_comb begin
    in_red_s   = (in_data == P_MOD) ? 31'd0 : in_data;
    in_fire_s  = in_valid && in_ready_r;
    out_fire_s = out_valid_r && out_ready;
    if (fsm_r == S_PAD) begin
      lane_sum_s = fadd(state_r[cnt_r], 31'd1);
    end else begin
      lane_sum_s = fadd(state_r[cnt_r], in_red_s);
    end
  end

  // Sponge sequencer: state register, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r       <= S_ABSORB;
      state_r     <= '0;
      cnt_r       <= 4'd0;
      idx_r       <= 4'd0;
      final_r     <= 1'b0;
      need_pad_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      perm_go_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (fsm_r)
        S_ABSORB: begin
          if (in_fire_s) begin
            state_r[cnt_r] <= lane_sum_s;
            if (cnt_r == RATE_LAST) begin
              // Full block: permute now; a final full block still owes a pad block.
              cnt_r      <= 4'd0;
              need_pad_r <= in_last;
              fsm_r      <= S_PERM;
              perm_go_r  <= 1'b1;
              in_ready_r <= 1'b0;
            end else if (in_last) begin
              cnt_r      <= cnt_r + 4'd1;
              fsm_r      <= S_PAD;
              in_ready_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        S_PAD: begin
          state_r[cnt_r] <= lane_sum_s;
          cnt_r          <= 4'd0;
          need_pad_r     <= 1'b0;
          final_r        <= 1'b1;
          fsm_r          <= S_PERM;
          perm_go_r      <= 1'b1;
        end
        S_PERM: begin
          if (perm_valid) begin
            // State is only written once go drops, so the core input stays stable.
            state_r   <= perm_state_out;
            perm_go_r <= 1'b0;
            if (final_r) begin
              fsm_r       <= S_SQUEEZE;
              idx_r       <= 4'd0;
              out_valid_r <= 1'b1;
              out_last_r  <= (OUT_LAST == 4'd0);
            end else if (need_pad_r) begin
              fsm_r <= S_PAD;
            end else begin
              fsm_r      <= S_ABSORB;
              in_ready_r <= 1'b1;
            end
          end
        end
        S_SQUEEZE: begin
          if (out_fire_s) begin
            if (out_last_r) begin
              state_r     <= '0;
              idx_r       <= 4'd0;
              final_r     <= 1'b0;
              fsm_r       <= S_ABSORB;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              in_ready_r  <= 1'b1;
            end else begin
              idx_r      <= idx_r + 4'd1;
              out_last_r <= ((idx_r + 4'd1) == OUT_LAST);
            end
          end
        end
        default: begin
          fsm_r <= S_ABSORB;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_r;
  assign perm_go       = perm_go_r;
  assign out_valid     = out_valid_r;
  assign out_last      = out_last_r;
  assign out_data      = state_r[idx_r];
  assign perm_state_in = state_r;
  assign busy          = !((fsm_r == S_ABSORB) && (cnt_r == 4'd0));

endmodule

// File: tb/tb_monolith_sponge_ctrl.sv
// Bench for monolith_sponge_ctrl: core stub adds 1 to every lane after a
// short delay; digests are compared with fixed vectors and with a sponge
// model computed from padded message blocks.
module tb_monolith_sponge_ctrl;
  localparam int          RATE    = 8;
  localparam int          OUT_LEN = 8;
  localparam logic [30:0] PM      = 31'h7FFF_FFFF;
  localparam longint      PL      = 64'd2147483647;

  logic              clk = 1'b0;
  logic              reset;
  logic [30:0]       in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [30:0]       out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              perm_go;
  logic [15:0][30:0] perm_state_in;
  logic [15:0][30:0] perm_state_out;
  logic              perm_valid = 1'b0;
  logic              busy;

  int tests  = 0;
  int failed = 0;

  logic [30:0] msg_q[$];
  logic [30:0] exp_q[$];
  logic [30:0] got_q[$];
  logic        lastf_q[$];

  always #5 clk = ~clk;

  monolith_sponge_ctrl #(.RATE(RATE), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .perm_go(perm_go), .perm_state_in(perm_state_in), .perm_state_out(perm_state_out),
    .perm_valid(perm_valid), .busy(busy)
  );

  // Core stub: result valid a few cycles after go rises, cleared when go drops.
  int stub_cnt = 0;
  always @(posedge clk) begin
    if (perm_go !== 1'b1) begin
      stub_cnt   <= 0;
      perm_valid <= 1'b0;
    end else if (stub_cnt == 2) begin
      perm_valid <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  // Core stub permutation: every lane plus one in the field.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      perm_state_out[i] = 31'((longint'(perm_state_in[i]) + 64'd1) % PL);
    end
  end

  // Protocol monitor, sampled on the falling edge.
  int proto_err = 0;
  int perm_starts = 0;
  logic prev_go = 1'b0, prev_fire = 1'b0, prev_stall = 1'b0, msg_done = 1'b0;
  logic [15:0][30:0] prev_psi = '0;
  logic [30:0] prev_od = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_go <= 1'b0; prev_fire <= 1'b0; prev_stall <= 1'b0; msg_done <= 1'b0;
    end else begin
      if (prev_go && perm_go && (perm_state_in !== prev_psi)) begin
        $display("protocol violation: perm_state_in changed during permutation"); proto_err <= proto_err + 1;
      end
      if (prev_fire && perm_go) begin
        $display("protocol violation: perm_go not dropped after perm_valid"); proto_err <= proto_err + 1;
      end
      if (msg_done && in_ready) begin
        $display("protocol violation: in_ready high during pad/perm/squeeze"); proto_err <= proto_err + 1;
      end
      if (perm_go && in_ready) begin
        $display("protocol violation: in_ready high with perm_go"); proto_err <= proto_err + 1;
      end
      if (out_valid && !msg_done) begin
        $display("protocol violation: out_valid without a finished message"); proto_err <= proto_err + 1;
      end
      if (prev_stall && (!out_valid || out_data !== prev_od)) begin
        $display("protocol violation: stalled output changed"); proto_err <= proto_err + 1;
      end
      if (perm_go && !prev_go) perm_starts <= perm_starts + 1;
      if (in_valid && in_ready && in_last) msg_done <= 1'b1;
      else if (out_valid && out_ready && out_last) msg_done <= 1'b0;
      else msg_done <= msg_done;
      prev_go    <= perm_go;
      prev_psi   <= perm_state_in;
      prev_fire  <= perm_go && perm_valid;
      prev_stall <= out_valid && !out_ready;
      prev_od    <= out_data;
    end
  end

  // Sponge reference: pad with 1 then zeros to a whole number of blocks.
  task automatic model_digest();
    longint st[16];
    longint v;
    int n, nblk, k;
    for (int i = 0; i < 16; i++) st[i] = 0;
    n = msg_q.size();
    nblk = n / RATE + 1;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < RATE; j++) begin
        k = b * RATE + j;
        if (k < n) v = (msg_q[k] == PM) ? 64'd0 : longint'(msg_q[k]);
        else if (k == n) v = 1;
        else v = 0;
        st[j] = (st[j] + v) % PL;
      end
      for (int i = 0; i < 16; i++) st[i] = (st[i] + 1) % PL;
    end
    exp_q.delete();
    for (int i = 0; i < OUT_LEN; i++) exp_q.push_back(31'(st[i]));
  endtask

  // Drive msg_q with optional random idle gaps; starts and ends just after a rising edge.
  task automatic send_msg(input int gap_max);
    int budget;
    for (int k = 0; k < msg_q.size(); k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = msg_q[k];
      in_last  = (k == msg_q.size() - 1);
      budget = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        budget++;
        if (budget > 2000) break;
      end
      @(posedge clk); #1;
      if (budget > 2000) begin
        tests++; failed++;
        $display("FAIL send_timeout: element %0d never accepted, in_ready=%b, want 1", k, in_ready);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 31'd0;
  endtask

  // Collect OUT_LEN digest elements with random backpressure.
  task automatic recv_digest(input int bp_pct);
    int budget = 0;
    got_q.delete(); lastf_q.delete();
    while (got_q.size() < OUT_LEN && budget < 3000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin got_q.push_back(out_data); lastf_q.push_back(out_last); end
      @(posedge clk); #1;
      out_ready = ($urandom_range(99, 0) >= bp_pct);
      budget++;
    end
    out_ready = 1'b1;
    tests++;
    if (got_q.size() != OUT_LEN) begin
      failed++;
      $display("FAIL recv_count: got %0d digest elements, want %0d", got_q.size(), OUT_LEN);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || perm_go !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: in_ready=%b perm_go=%b out_valid=%b out_last=%b busy=%b, want 1 0 0 0 0",
               in_ready, perm_go, out_valid, out_last, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    msg_q = {31'd5};
    exp_q = {31'd6, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
    send_msg(0);
    recv_digest(0);
    for (int i = 0; i < OUT_LEN; i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || lastf_q[i] !== (i == OUT_LEN - 1)) begin
        failed++;
        $display("FAIL single[%0d]: got %h last=%b, want %h last=%b", i,
                 (i < got_q.size()) ? got_q[i] : 31'd0, (i < lastf_q.size()) ? lastf_q[i] : 1'b0,
                 exp_q[i], (i == OUT_LEN - 1));
      end
    end
  endtask

  task automatic test_full_block();
    int starts0, err0;
    starts0 = perm_starts; err0 = proto_err;
    msg_q = {31'd1, 31'd2, 31'd3, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8};
    exp_q = {31'd4, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8, 31'd9, 31'd10};
    send_msg(0);
    recv_digest(0);
    for (int i = 0; i < OUT_LEN; i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || lastf_q[i] !== (i == OUT_LEN - 1)) begin
        failed++;
        $display("FAIL full_block[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 31'd0, exp_q[i]);
      end
    end
    tests++;
    if (perm_starts - starts0 != 2) begin
      failed++;
      $display("FAIL full_block_perms: got %0d permutations, want 2", perm_starts - starts0);
    end
    tests++;
    if (proto_err != err0) begin
      failed++;
      $display("FAIL full_block_protocol: got %0d violations, want 0", proto_err - err0);
    end
  endtask

  task automatic test_wrap();
    for (int v = 0; v < 2; v++) begin
      msg_q.delete();
      msg_q.push_back(31'h7FFF_FFFD);
      for (int i = 0; i < 7; i++) msg_q.push_back((v == 0) ? 31'd0 : PM);
      msg_q.push_back(31'd3);
      exp_q = {31'd3, 31'd3, 31'd2, 31'd2, 31'd2, 31'd2, 31'd2, 31'd2};
      send_msg(1);
      recv_digest(20);
      for (int i = 0; i < OUT_LEN; i++) begin
        tests++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          failed++;
          $display("FAIL wrap%0d[%0d]: got %h, want %h", v, i, (i < got_q.size()) ? got_q[i] : 31'd0, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int budget = 0;
    int stall_left = 5;
    int err0;
    err0 = proto_err;
    msg_q = {31'd1, 31'd2, 31'd3, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8};
    exp_q = {31'd4, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8, 31'd9, 31'd10};
    send_msg(0);
    got_q.delete(); lastf_q.delete();
    out_ready = 1'b1;
    while (got_q.size() < OUT_LEN && budget < 3000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin got_q.push_back(out_data); lastf_q.push_back(out_last); end
      if (stall_left > 0 && !out_ready) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp_q[3] || in_ready !== 1'b0) begin
          failed++;
          $display("FAIL stall: out_valid=%b out_data=%h in_ready=%b, want 1 %h 0", out_valid, out_data, in_ready, exp_q[3]);
        end
        stall_left--;
      end
      @(posedge clk); #1;
      out_ready = !(got_q.size() == 3 && stall_left > 0);
      budget++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < OUT_LEN; i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || lastf_q[i] !== (i == OUT_LEN - 1)) begin
        failed++;
        $display("FAIL backpressure[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 31'd0, exp_q[i]);
      end
    end
    tests++;
    if (proto_err != err0) begin
      failed++;
      $display("FAIL backpressure_protocol: got %0d violations, want 0", proto_err - err0);
    end
  endtask

  task automatic test_reset_mid_perm();
    int budget = 0;
    msg_q = {31'd5};
    send_msg(0);
    while (perm_go !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (perm_go !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_perm: perm_go=%b in_ready=%b busy=%b out_valid=%b, want 0 1 0 0",
               perm_go, in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
    exp_q = {31'd6, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
    send_msg(0);
    recv_digest(0);
    for (int i = 0; i < OUT_LEN; i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL after_reset[%0d]: got %h, want %h", i, (i < got_q.size()) ? got_q[i] : 31'd0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int err0, len, r;
    err0 = proto_err;
    for (int m = 0; m < 25; m++) begin
      msg_q.delete();
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(9, 0);
        if (r == 0) msg_q.push_back(PM);
        else if (r == 1) msg_q.push_back(PM - 31'd1);
        else msg_q.push_back(31'($urandom));
      end
      model_digest();
      send_msg((m % 2 == 0) ? 0 : 2);
      recv_digest((m % 3 == 0) ? 0 : 40);
      for (int i = 0; i < OUT_LEN; i++) begin
        tests++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i] || lastf_q[i] !== (i == OUT_LEN - 1)) begin
          failed++;
          $display("FAIL random%0d[%0d] len=%0d: got %h, want %h", m, i, len,
                   (i < got_q.size()) ? got_q[i] : 31'd0, exp_q[i]);
        end
      end
    end
    tests++;
    if (proto_err != err0) begin
      failed++;
      $display("FAIL random_protocol: got %0d violations, want 0", proto_err - err0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 31'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_single();
    test_full_block();
    test_wrap();
    test_backpressure();
    test_reset_mid_perm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/monolith_sponge_ctrl.md
Name: monolith_sponge_ctrl

Overview:
Sponge-mode sequencer for the Monolith permutation core over GF(p), where p = 2^31-1. It accepts a message stream of field elements on a valid/ready interface and absorbs them RATE elements at a time into a 16-lane state. It applies 10* padding and drives the core's held-go/valid protocol for each permutation. After the final permutation it streams OUT_LEN digest elements on a valid/ready output. It sits between the system stream fabric and one monolith_hash instance.

Parameters:
RATE, 8, elements absorbed per permutation; legal range 1..15; lanes RATE..15 are capacity.
OUT_LEN, 8, digest elements emitted per message; legal range 1..RATE.

Ports:
clk  input  1  clock, positive edge
reset  input  1  synchronous, active-high
in_data  input  31  message element
in_valid  input  1  in_data valid
in_last  input  1  marks last element of message; qualified by in_valid
in_ready  output  1  controller accepts in_data this cycle
out_data  output  31  digest element
out_valid  output  1  out_data valid
out_last  output  1  marks final digest element
out_ready  input  1  downstream accepts out_data
perm_go  output  1  core go; held high for whole permutation; low resets core
perm_state_in  output  16x31  state presented to core
perm_state_out  input  16x31  permuted state from core
perm_valid  input  1  core result valid; stays high while perm_go is high
busy  output  1  high in every state except ABSORB with cnt==0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (any state, including mid-PERM or mid-SQUEEZE):
  - registers cleared: state=0, cnt=0, idx=0, final=0, need_pad=0.
  - outputs: FSM enters ABSORB, perm_go=0, out_valid=0, out_last=0, in_ready=1 from the first cycle after reset deasserts.
- perm_state_in is driven directly from the state register. state is never written while perm_go=1, so perm_state_in is stable throughout each permutation.
- Field add: add(a,b) = a+b in 32 bits; subtract p if the sum is >= p. in_data of 0x7FFFFFFF is reduced to 0 before the add.
- ABSORB:
  - in_ready=1.
  - On in_valid && in_ready: state[cnt] <= add(state[cnt], in_data), then:
    - block full (cnt==RATE-1): cnt<=0, go to PERM. If in_last, set need_pad=1.
    - else if in_last: cnt<=cnt+1, go to PAD.
    - else: cnt<=cnt+1, stay in ABSORB.
- PAD (one cycle, perm_go=0, in_ready=0): state[cnt] <= add(state[cnt],1); remaining rate lanes are unchanged (zero added). cnt<=0, need_pad<=0, final<=1, go to PERM.
- PERM:
  - perm_go=1 from the first PERM cycle; in_ready=0.
  - On perm_valid: state <= perm_state_out. perm_go is 0 in the following cycle.
  - Next state: SQUEEZE if final; else PAD if need_pad; else ABSORB.
  - Every path out of PERM holds perm_go low for at least one cycle before the next PERM.
  - Core latency is unspecified; the controller waits indefinitely.
- SQUEEZE:
  - out_valid=1, out_data=state[idx], out_last=(idx==OUT_LEN-1), in_ready=0.
  - out_data is stable while out_valid && !out_ready.
  - On handshake: idx<=idx+1. On the handshake with out_last: state<=0, idx<=0, final<=0, go to ABSORB; out_valid=0 in the next cycle.
- Message length is at least 1 (in_last is carried on a data element). No zero-length messages.
- in_valid outside ABSORB is ignored and must be held by the source (standard valid/ready).
- perm_valid outside PERM is ignored.

Test Plan:
Bench core stub: with perm_go held, asserts perm_valid after 3 cycles and returns out[i] = add(in[i],1) for all 16 lanes. RATE=8, OUT_LEN=8.
1. Single element 5 with in_last -> padded block [5,1,0..0], one permutation, digest 6,2,1,1,1,1,1,1; out_last on the 8th element.
2. Elements 1..8, in_last on 8 -> perm, extra pad block, second perm; digest 4,4,5,6,7,8,9,10.
3. Elements 0x7FFFFFFD, seven zeros, then 3 with in_last -> lane0 wraps to 2; digest 3,3,2,2,2,2,2,2. Repeat with 0x7FFFFFFF in place of the zeros -> identical digest.
4. out_ready low for 5 cycles mid-digest -> out_valid held high, out_data stable, in_ready=0, no element lost or duplicated.
5. Case 2 protocol checks -> perm_go low for at least 1 cycle between the two permutations; perm_state_in constant while perm_go=1; in_ready=0 during PAD, PERM and SQUEEZE.
6. reset pulse on the 2nd PERM cycle -> perm_go=0 and in_ready=1 the cycle after reset drops, busy=0; then send 5 with in_last -> same digest as case 1.
